// File: rtl/alu_req_issuer.sv
// Request FIFO plus issue sequencer feeding the ALU operand/command pins.
// Each popped request becomes one or two registered beats, followed by a settle gap.
module alu_req_issuer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_opa,
    input  logic [WIDTH-1:0] req_opb,
    input  logic [3:0]       req_cmd,
    input  logic             req_mode,
    input  logic             req_cin,
    input  logic [1:0]       req_inp_valid,
    input  logic             req_split,
    output logic [WIDTH-1:0] opa,
    output logic [WIDTH-1:0] opb,
    output logic [3:0]       cmd,
    output logic             mode,
    output logic             cin,
    output logic [1:0]       inp_valid,
    output logic             ce,
    output logic             busy,
    output logic [7:0]       issued_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic [3:0]       cmd;
        logic             mode;
        logic             cin;
        logic [1:0]       iv;
        logic             split;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_BEAT_A, S_BEAT_B, S_GAP} state_t;

    entry_t           r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic             r_rdy_en;
    state_t           r_state, w_nxt_state;
    logic [1:0]       r_gap, w_nxt_gap;
    entry_t           r_ent, w_nxt_ent;
    logic [WIDTH-1:0] r_opa, r_opb, w_nxt_opa, w_nxt_opb;
    logic [3:0]       r_cmd, w_nxt_cmd;
    logic             r_mode, r_cin, w_nxt_mode, w_nxt_cin;
    logic [1:0]       r_iv, w_nxt_iv;
    logic             r_ce;
    logic [7:0]       r_cnt;

    logic [AW:0]      w_count;
    logic             w_full, w_empty, w_push, w_pop, w_inc, w_launch;
    entry_t           w_req, w_head;
    logic [1:0]       w_ent_gap;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    // r_rdy_en keeps req_ready low until the first edge after reset release
    assign req_ready = r_rdy_en && !w_full;
    assign w_push    = req_valid && req_ready;
    assign w_req     = {req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid,
                        req_split && (req_inp_valid == 2'b11)};
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    // Multiply commands in arithmetic mode need an extra settle cycle
    assign w_ent_gap = (r_ent.mode && (r_ent.cmd == 4'd9 || r_ent.cmd == 4'd10)) ? 2'd2 : 2'd1;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_req;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gap   = r_gap;
        w_nxt_ent   = r_ent;
        w_nxt_opa   = r_opa;
        w_nxt_opb   = r_opb;
        w_nxt_cmd   = r_cmd;
        w_nxt_mode  = r_mode;
        w_nxt_cin   = r_cin;
        w_nxt_iv    = r_iv;
        w_pop       = 1'b0;
        w_inc       = 1'b0;
        w_launch    = 1'b0;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    w_nxt_iv = 2'b00;
                    w_launch = !w_empty;
                end
                S_BEAT_A: begin
                    w_nxt_state = S_BEAT_B;
                    w_nxt_opa   = r_ent.opa;
                    w_nxt_opb   = r_ent.opb;
                    w_nxt_cmd   = r_ent.cmd;
                    w_nxt_mode  = r_ent.mode;
                    w_nxt_cin   = r_ent.cin;
                    w_nxt_iv    = r_ent.split ? 2'b11 : r_ent.iv;
                    w_inc       = 1'b1;
                end
                S_BEAT_B: begin
                    w_nxt_state = S_GAP;
                    w_nxt_iv    = 2'b00;
                    w_nxt_gap   = w_ent_gap;
                end
                S_GAP: begin
                    w_nxt_iv = 2'b00;
                    if (r_gap > 2'd1) begin
                        w_nxt_gap = r_gap - 2'd1;
                    end else begin
                        w_launch = !w_empty;
                        if (w_empty) w_nxt_state = S_IDLE;
                    end
                end
                default: w_nxt_state = S_IDLE;
            endcase
            // Pop the head and present its first beat on the same edge
            if (w_launch) begin
                w_pop      = 1'b1;
                w_nxt_ent  = w_head;
                w_nxt_opa  = w_head.opa;
                w_nxt_cmd  = w_head.cmd;
                w_nxt_mode = w_head.mode;
                w_nxt_cin  = w_head.cin;
                if (w_head.split) begin
                    w_nxt_state = S_BEAT_A;
                    w_nxt_opb   = '0;
                    w_nxt_iv    = 2'b01;
                end else begin
                    w_nxt_state = S_BEAT_B;
                    w_nxt_opb   = w_head.opb;
                    w_nxt_iv    = w_head.iv;
                    w_inc       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rdy_en <= 1'b0;
            r_state  <= S_IDLE;
            r_gap    <= '0;
            r_ent    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_cmd    <= '0;
            r_mode   <= 1'b0;
            r_cin    <= 1'b0;
            r_iv     <= 2'b00;
            r_ce     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            r_ce     <= en;
            r_state  <= w_nxt_state;
            r_gap    <= w_nxt_gap;
            r_ent    <= w_nxt_ent;
            r_opa    <= w_nxt_opa;
            r_opb    <= w_nxt_opb;
            r_cmd    <= w_nxt_cmd;
            r_mode   <= w_nxt_mode;
            r_cin    <= w_nxt_cin;
            r_iv     <= w_nxt_iv;
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_inc)  r_cnt    <= r_cnt + 8'd1;
        end
    end

    assign opa        = r_opa;
    assign opb        = r_opb;
    assign cmd        = r_cmd;
    assign mode       = r_mode;
    assign cin        = r_cin;
    assign inp_valid  = r_iv;
    assign ce         = r_ce;
    assign issued_cnt = r_cnt;
    assign busy       = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_req_issuer.sv
// Bench for alu_req_issuer: directed scenarios plus a random stream checked
// against a beat/timing model derived from the issue-spacing rules.
module tb_alu_req_issuer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic [1:0] iv;
        logic       split;
    } req_t;

    logic       clk = 1'b0, reset = 1'b0, en = 1'b0, req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_opa = '0, req_opb = '0, opa, opb;
    logic [3:0] req_cmd = '0, cmd;
    logic       req_mode = 1'b0, req_cin = 1'b0, req_split = 1'b0, mode, cin, ce, busy;
    logic [1:0] req_inp_valid = '0, inp_valid;
    logic [7:0] issued_cnt;

    alu_req_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd), .req_mode(req_mode),
        .req_cin(req_cin), .req_inp_valid(req_inp_valid), .req_split(req_split),
        .opa(opa), .opb(opb), .cmd(cmd), .mode(mode), .cin(cin), .inp_valid(inp_valid),
        .ce(ce), .busy(busy), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0;
    bit mon_on = 1'b0;
    logic [23:0] obs_b[$], exp_b[$];
    int obs_c[$], exp_c[$];
    int t_next = 0;
    int exp_issued = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every beat the ALU actually clocks in (ce high, non-zero operand code)
    always @(negedge clk)
        if (mon_on && ce && inp_valid != 2'b00) begin
            obs_b.push_back({opa, opb, cmd, mode, cin, inp_valid});
            obs_c.push_back(cyc);
        end

    function automatic req_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                                input logic m, input logic ci, input logic [1:0] iv, input logic s);
        req_t r;
        r.opa = a; r.opb = b; r.cmd = c; r.mode = m; r.cin = ci; r.iv = iv; r.split = s;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.opa   = 8'($urandom);
        r.opb   = 8'($urandom);
        r.cmd   = ($urandom_range(0, 2) == 0) ? 4'(9 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
        r.mode  = 1'($urandom_range(0, 1));
        r.cin   = 1'($urandom_range(0, 1));
        r.iv    = 2'($urandom_range(1, 3));
        r.split = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic req_t norm_req();
        return mk(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)), 2'b11, 1'b0);
    endfunction

    task automatic drive(input req_t r);
        req_opa = r.opa; req_opb = r.opb; req_cmd = r.cmd; req_mode = r.mode;
        req_cin = r.cin; req_inp_valid = r.iv; req_split = r.split;
    endtask

    task automatic model_clear();
        exp_b.delete(); exp_c.delete(); obs_b.delete(); obs_c.delete();
        t_next = 0;
    endtask

    // Expected beats with their cycle offsets from the first beat, assuming the queue never runs dry
    task automatic model_push(input req_t r);
        int g;
        g = (r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10)) ? 2 : 1;
        if (r.split && r.iv == 2'b11) begin
            exp_b.push_back({r.opa, 8'h00, r.cmd, r.mode, r.cin, 2'b01}); exp_c.push_back(t_next);
            exp_b.push_back({r.opa, r.opb, r.cmd, r.mode, r.cin, 2'b11}); exp_c.push_back(t_next + 1);
            t_next += 2 + g;
        end else begin
            exp_b.push_back({r.opa, r.opb, r.cmd, r.mode, r.cin, r.iv}); exp_c.push_back(t_next);
            t_next += 1 + g;
        end
        exp_issued++;
    endtask

    task automatic push_one(input req_t r, input bit mdl);
        int g = 0;
        @(negedge clk); drive(r); req_valid = 1'b1;
        while (!req_ready && g < 200) begin @(negedge clk); g++; end
        total_cnt++;
        if (g >= 200) $display("FAIL push_timeout ready=%b required 1", req_ready);
        else pass_cnt++;
        if (mdl) model_push(r);
    endtask

    task automatic stream(input int n, input bit normal_only);
        req_t r;
        int acc = 0, g = 0;
        r = normal_only ? norm_req() : rnd_req();
        while (acc < n && g < n * 8 + 50) begin
            @(negedge clk); g++; drive(r); req_valid = 1'b1;
            if (req_ready) begin
                model_push(r); acc++;
                r = normal_only ? norm_req() : rnd_req();
            end
        end
        @(negedge clk); req_valid = 1'b0;
        total_cnt++;
        if (acc !== n) $display("FAIL stream_accept got %0d required %0d", acc, n);
        else pass_cnt++;
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin @(negedge clk); g++; end while (busy && g < 3000);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL drain_timeout busy=%b required 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; req_valid = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({opa, opb, cmd, mode, cin, inp_valid} !== 24'h0)
            $display("FAIL reset_pins got %h required 0", {opa, opb, cmd, mode, cin, inp_valid});
        else pass_cnt++;
        total_cnt++;
        if ({ce, busy, req_ready, issued_cnt} !== 11'h0)
            $display("FAIL reset_status ce=%b busy=%b ready=%b cnt=%0d required all 0", ce, busy, req_ready, issued_cnt);
        else pass_cnt++;
        reset = 1'b1; #1;
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL ready_before_edge got %b required 0", req_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_edge got %b required 1", req_ready);
        else pass_cnt++;
        exp_issued = 0;
        @(negedge clk); en = 1'b1;
    endtask

    task automatic test_normal();
        model_clear(); mon_on = 1'b1;
        @(negedge clk); drive(mk(8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b11, 1'b0)); req_valid = 1'b1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL normal_ready got %b required 1", req_ready);
        else pass_cnt++;
        model_push(mk(8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b11, 1'b0));
        @(negedge clk); req_valid = 1'b0;
        total_cnt++;
        if (inp_valid !== 2'b00 || busy !== 1'b1)
            $display("FAIL normal_latency iv=%b busy=%b required iv=00 busy=1", inp_valid, busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({opa, opb, cmd, mode, inp_valid, ce} !== {8'h12, 8'h34, 4'd0, 1'b1, 2'b11, 1'b1})
            $display("FAIL normal_beat got %h/%h/%h m%b iv%b ce%b required 12/34/0 m1 iv11 ce1", opa, opb, cmd, mode, inp_valid, ce);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (inp_valid !== 2'b00 || opa !== 8'h12 || opb !== 8'h34)
            $display("FAIL normal_gap iv=%b opa=%h opb=%h required 00/12/34", inp_valid, opa, opb);
        else pass_cnt++;
        total_cnt++;
        if (issued_cnt !== 8'(exp_issued)) $display("FAIL normal_cnt got %0d required %0d", issued_cnt, exp_issued);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL normal_idle busy=%b required 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_split();
        model_clear();
        @(negedge clk); drive(mk(8'hFF, 8'h01, 4'd3, 1'b0, 1'b1, 2'b11, 1'b1)); req_valid = 1'b1;
        model_push(mk(8'hFF, 8'h01, 4'd3, 1'b0, 1'b1, 2'b11, 1'b1));
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({opa, opb, inp_valid} !== {8'hFF, 8'h00, 2'b01})
            $display("FAIL split_beat_a got %h/%h iv%b required FF/00 iv01", opa, opb, inp_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({opa, opb, cmd, inp_valid} !== {8'hFF, 8'h01, 4'd3, 2'b11})
            $display("FAIL split_beat_b got %h/%h/%h iv%b required FF/01/3 iv11", opa, opb, cmd, inp_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (inp_valid !== 2'b00) $display("FAIL split_gap iv=%b required 00", inp_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || issued_cnt !== 8'(exp_issued))
            $display("FAIL split_done busy=%b cnt=%0d required 0/%0d", busy, issued_cnt, exp_issued);
        else pass_cnt++;
    endtask

    task automatic test_mult_spacing();
        logic [3:0] c1 [3] = '{4'd9, 4'd9, 4'd10};
        logic       m1 [3] = '{1'b1, 1'b0, 1'b1};
        int         sp [3] = '{3, 2, 3};
        for (int k = 0; k < 3; k++) begin
            model_clear();
            push_one(mk(8'h21, 8'h03, c1[k], m1[k], 1'b0, 2'b11, 1'b0), 1'b1);
            push_one(mk(8'h44, 8'h05, 4'd1, 1'b1, 1'b0, 2'b11, 1'b0), 1'b1);
            @(negedge clk); req_valid = 1'b0;
            wait_idle();
            total_cnt++;
            if (obs_c.size() != 2) $display("FAIL mult_beats case%0d got %0d required 2", k, obs_c.size());
            else if (obs_c[1] - obs_c[0] !== sp[k])
                $display("FAIL mult_spacing case%0d got %0d required %0d", k, obs_c[1] - obs_c[0], sp[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_full();
        req_t reqs [6];
        int i = 0;
        for (int k = 0; k < 6; k++) begin reqs[k] = rnd_req(); reqs[k].opa = 8'(8'h60 + k); end
        model_clear();
        @(negedge clk); en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); drive(reqs[i < 6 ? i : 5]); req_valid = (i < 6);
            if (i < 6 && req_ready) begin model_push(reqs[i]); i++; end
        end
        @(negedge clk); req_valid = 1'b0;
        total_cnt++;
        if (i !== DEPTH) $display("FAIL full_accepted got %0d required %0d", i, DEPTH);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 1'b0 || ce !== 1'b0 || busy !== 1'b1 || inp_valid !== 2'b00)
            $display("FAIL full_frozen ready=%b ce=%b busy=%b iv=%b required 0/0/1/00", req_ready, ce, busy, inp_valid);
        else pass_cnt++;
        en = 1'b1;
        wait_idle();
        total_cnt++;
        if (obs_b.size() !== exp_b.size()) $display("FAIL full_beats got %0d required %0d", obs_b.size(), exp_b.size());
        else pass_cnt++;
        for (int k = 0; k < obs_b.size() && k < exp_b.size(); k++) begin
            total_cnt++;
            if (obs_b[k] !== exp_b[k] || obs_c[k] - obs_c[0] !== exp_c[k])
                $display("FAIL full_beat%0d got %h @%0d required %h @%0d", k, obs_b[k], obs_c[k] - obs_c[0], exp_b[k], exp_c[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        model_clear();
        stream(40, 1'b0);
        wait_idle();
        total_cnt++;
        if (obs_b.size() !== exp_b.size()) $display("FAIL rand_beats got %0d required %0d", obs_b.size(), exp_b.size());
        else pass_cnt++;
        for (int k = 0; k < obs_b.size() && k < exp_b.size(); k++) begin
            total_cnt++;
            if (obs_b[k] !== exp_b[k] || obs_c[k] - obs_c[0] !== exp_c[k])
                $display("FAIL rand_beat%0d got %h @%0d required %h @%0d", k, obs_b[k], obs_c[k] - obs_c[0], exp_b[k], exp_c[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (issued_cnt !== 8'(exp_issued)) $display("FAIL rand_cnt got %0d required %0d", issued_cnt, 8'(exp_issued));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); en = 1'b0;
        for (int k = 0; k < 3; k++) push_one(mk(8'(8'hB0 + k), 8'h11, 4'd9, 1'b1, 1'b0, 2'b11, 1'b0), 1'b0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1 reset = 1'b0; #1;
        total_cnt++;
        if ({opa, opb, cmd, mode, cin, inp_valid} !== 24'h0)
            $display("FAIL midreset_pins got %h required 0", {opa, opb, cmd, mode, cin, inp_valid});
        else pass_cnt++;
        total_cnt++;
        if ({ce, busy, req_ready, issued_cnt} !== 11'h0)
            $display("FAIL midreset_status ce=%b busy=%b ready=%b cnt=%0d required all 0", ce, busy, req_ready, issued_cnt);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b1; exp_issued = 0; model_clear();
        push_one(mk(8'hA5, 8'h5A, 4'd2, 1'b0, 1'b0, 2'b11, 1'b0), 1'b1);
        @(negedge clk); req_valid = 1'b0;
        wait_idle();
        total_cnt++;
        if (obs_b.size() != 1) $display("FAIL midreset_beats got %0d required 1", obs_b.size());
        else if (obs_b[0] !== exp_b[0]) $display("FAIL midreset_beat got %h required %h", obs_b[0], exp_b[0]);
        else pass_cnt++;
        total_cnt++;
        if (issued_cnt !== 8'd1) $display("FAIL midreset_cnt got %0d required 1", issued_cnt);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1; exp_issued = 0; model_clear();
        stream(256, 1'b1);
        wait_idle();
        total_cnt++;
        if (obs_b.size() !== 256) $display("FAIL wrap_beats got %0d required 256", obs_b.size());
        else pass_cnt++;
        total_cnt++;
        if (issued_cnt !== 8'h00 || busy !== 1'b0)
            $display("FAIL wrap_cnt got cnt=%0d busy=%b required 0/0", issued_cnt, busy);
        else pass_cnt++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_split();
        test_mult_spacing();
        test_full();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
